sc_mul_sched: RTL and testbench

- Job-level scheduler for a CAPE-style stochastic-computing multiplier with early termination.
- Accepts one operand set (NUM_INPUTS binary values plus a truncation mask) over a valid/ready handshake.
- Runs an internal interleaved bypass counter that generates the NUM_INPUTS bitstreams and accumulates the popcount of their AND.
- Returns the ones-count and the run length over a second valid/ready handshake. Sits between a host/DMA front end and result storage.

---
 rtl/sc_mul_sched.sv | 142 ++++++++++++++
 tb/tb_sc_mul_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : sc_mul_sched
// Brief    : Job scheduler for a stochastic-computing multiplier with
//            bypass-based early termination.
// Revision : 1.0
// ============================================================================
module sc_mul_sched #(
    parameter int WIDTH      = 4,
    parameter int NUM_INPUTS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH*NUM_INPUTS-1:0]   in_bxs,
    input  logic [WIDTH-1:0]              in_trunc,
    input  logic                          abort,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH*NUM_INPUTS:0]     out_count,
    output logic [WIDTH*NUM_INPUTS:0]     out_cycles,
    output logic                          busy
);

    localparam int CW = WIDTH * NUM_INPUTS;
    localparam logic [CW:0] C_ONE = {{CW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   bt_q, bt_d;
    logic [CW-1:0]   bp_q, bp_d;
    logic [CW:0]     acc_q, acc_d;
    logic [CW:0]     len_q, len_d;
    logic [CW:0]     count_q, count_d;
    logic [CW:0]     cycles_q, cycles_d;

    logic [CW-1:0]         w_bt_new;
    logic [CW-1:0]         w_bp_new;
    logic [CW-1:0]         w_lanes;
    logic [NUM_INPUTS-1:0] w_x;
    logic                  w_hit;
    logic [CW:0]           w_sum;
    logic                  w_carry;
    logic [CW-1:0]         w_cnt_next;

    // Bit j of operand i is bypassed when bits 0..j of its truncated value are
    // all zero, i.e. j lies below its trailing-zero count.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        assign w_bt_new[i*WIDTH +: WIDTH] = in_bxs[i*WIDTH +: WIDTH] & ~in_trunc;
        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            assign w_bp_new[j*NUM_INPUTS + i] = ~|w_bt_new[i*WIDTH +: j+1];
            assign w_lanes[i*WIDTH + j]       = cnt_q[j*NUM_INPUTS + i];
        end
        assign w_x[i] = (w_lanes[i*WIDTH +: WIDTH] < bt_q[i*WIDTH +: WIDTH]);
    end

    assign w_hit      = &w_x;
    // Forcing bypassed bits to one lets the increment ripple straight past them.
    assign w_sum      = {1'b0, cnt_q | bp_q} + C_ONE;
    assign w_carry    = w_sum[CW];
    assign w_cnt_next = w_sum[CW-1:0] & ~bp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bt_q     <= '0;
            bp_q     <= '0;
            acc_q    <= '0;
            len_q    <= '0;
            count_q  <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bt_q     <= bt_d;
            bp_q     <= bp_d;
            acc_q    <= acc_d;
            len_q    <= len_d;
            count_q  <= count_d;
            cycles_q <= cycles_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bt_d     = bt_q;
        bp_d     = bp_q;
        acc_d    = acc_q;
        len_d    = len_q;
        count_d  = count_q;
        cycles_d = cycles_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && !abort) begin
                    bt_d    = w_bt_new;
                    bp_d    = w_bp_new;
                    cnt_d   = '0;
                    acc_d   = '0;
                    len_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_q + {{CW{1'b0}}, w_hit};
                    len_d = len_q + C_ONE;
                    cnt_d = w_cnt_next;
                    if (w_carry) begin
                        state_d  = ST_DONE;
                        count_d  = acc_q + {{CW{1'b0}}, w_hit};
                        cycles_d = len_q + C_ONE;
                    end
                end
            end
            ST_DONE: begin
                if (abort || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q == ST_RUN);
    assign out_count  = count_q;
    assign out_cycles = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_mul_sched
// Brief    : Self-checking bench for sc_mul_sched against a closed-form model.
// Revision : 1.0
// ============================================================================
module tb_sc_mul_sched;

    localparam int WIDTH = 4;
    localparam int NI    = 2;
    localparam int CW    = WIDTH * NI;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CW-1:0]     in_bxs = '0;
    logic [WIDTH-1:0]  in_trunc = '0;
    logic              abort = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CW:0]       out_count;
    logic [CW:0]       out_cycles;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    sc_mul_sched #(.WIDTH(WIDTH), .NUM_INPUTS(NI)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bxs     (in_bxs),
        .in_trunc   (in_trunc),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_cycles (out_cycles),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Lane i visits every multiple of 2^tz_i below 2^WIDTH once per combination
    // of the other lanes, so hits = prod(bt_i >> tz_i), length = 2^(CW - sum tz).
    function automatic void model_job(input logic [CW-1:0] bxs, input logic [WIDTH-1:0] trunc,
                                      output int cnt, output int len);
        int sumtz;
        sumtz = 0;
        cnt   = 1;
        for (int i = 0; i < NI; i++) begin
            logic [WIDTH-1:0] bt;
            int tz;
            bt = bxs[i*WIDTH +: WIDTH] & ~trunc;
            tz = WIDTH;
            for (int j = WIDTH-1; j >= 0; j--) if (bt[j]) tz = j;
            sumtz += tz;
            cnt   *= (tz >= WIDTH) ? 0 : int'(bt >> tz);
        end
        len = 1 << (CW - sumtz);
    endfunction

    // Reference timeline: 0 = waiting for a job, 1 = running, 2 = result held
    int m_phase = 0, m_left = 0, m_count = 0, m_cycles = 0, p_count = 0, p_len = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  = 0;
            m_count  = 0;
            m_cycles = 0;
        end else begin
            case (m_phase)
                0: if (!abort && in_valid) begin
                    model_job(in_bxs, in_trunc, p_count, p_len);
                    m_left  = p_len;
                    m_phase = 1;
                end
                1: if (abort) m_phase = 0;
                   else begin
                       m_left--;
                       if (m_left == 0) begin
                           m_phase  = 2;
                           m_count  = p_count;
                           m_cycles = p_len;
                       end
                   end
                default: if (abort || out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready",   in_ready,   m_phase == 0);
            chk("out_valid",  out_valid,  m_phase == 2);
            chk("busy",       busy,       m_phase == 1);
            chk("out_count",  out_count,  m_count);
            chk("out_cycles", out_cycles, m_cycles);
        end
    end

    task automatic send(input logic [CW-1:0] b, input logic [WIDTH-1:0] t);
        int g;
        g = 0;
        while (!in_ready && g < 600) begin @(negedge clk); g++; end
        chk("send_ready_timeout", in_ready, 1);
        in_bxs   = b;
        in_trunc = t;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_bxs   = CW'($urandom);
        in_trunc = WIDTH'($urandom);
    endtask

    task automatic job(input logic [CW-1:0] b, input logic [WIDTH-1:0] t,
                       input int exp_cnt, input int exp_len, input int hold);
        int g, n;
        send(b, t);
        g = 0;
        n = 0;
        while (!out_valid && g < 600) begin
            if (busy) n++;
            @(negedge clk);
            g++;
        end
        chk("done_timeout", out_valid, 1);
        chk("lit_run_len",  n,          exp_len);
        chk("lit_count",    out_count,  exp_cnt);
        chk("lit_cycles",   out_cycles, exp_len);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_valid",    out_valid,  1);
            chk("hold_in_ready", in_ready,   0);
            chk("hold_count",    out_count,  exp_cnt);
            chk("hold_cycles",   out_cycles, exp_len);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_consume_valid", out_valid, 0);
    endtask

    initial begin
        int c, l;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",   in_ready,   1);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_busy",       busy,       0);
        chk("rst_out_count",  out_count,  0);
        chk("rst_out_cycles", out_cycles, 0);
        rst_n    = 1'b1;
        check_en = 1'b1;

        model_job({4'd15, 4'd15}, 4'b0000, c, l); chk("model_ff_cnt", c, 225); chk("model_ff_len", l, 256);
        model_job({4'd8,  4'd8 }, 4'b0000, c, l); chk("model_88_cnt", c, 1);   chk("model_88_len", l, 4);
        model_job({4'd5,  4'd7 }, 4'b0011, c, l); chk("model_75_cnt", c, 1);   chk("model_75_len", l, 16);
        model_job({4'd9,  4'd0 }, 4'b0000, c, l); chk("model_09_cnt", c, 0);   chk("model_09_len", l, 16);
        model_job({4'd0,  4'd0 }, 4'b0000, c, l); chk("model_00_cnt", c, 0);   chk("model_00_len", l, 1);

        job({4'd15, 4'd15}, 4'b0000, 225, 256, 0);
        job({4'd8,  4'd8 }, 4'b0000, 1,   4,   0);
        job({4'd5,  4'd7 }, 4'b0011, 1,   16,  10);
        job({4'd9,  4'd0 }, 4'b0000, 0,   16,  0);
        job({4'd0,  4'd0 }, 4'b0000, 0,   1,   2);

        // Abort part-way through a long run
        send({4'd15, 4'd15}, 4'b0000);
        repeat (49) @(negedge clk);
        chk("pre_abort_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_valid",    out_valid, 0);
        chk("abort_busy",     busy, 0);
        job({4'd8, 4'd8}, 4'b0000, 1, 4, 0);

        // Abort in idle wins over a simultaneous offer
        in_valid = 1'b1;
        abort    = 1'b1;
        in_bxs   = {4'd15, 4'd15};
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        chk("idle_abort_busy", busy, 0);

        // Abort while a result is held
        send({4'd8, 4'd8}, 4'b0000);
        repeat (6) @(negedge clk);
        chk("done_before_abort", out_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("done_abort_valid", out_valid, 0);

        // Asynchronous reset in the middle of a run
        send({4'd15, 4'd15}, 4'b0000);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   busy,       0);
        chk("mid_rst_ready",  in_ready,   1);
        chk("mid_rst_valid",  out_valid,  0);
        chk("mid_rst_count",  out_count,  0);
        chk("mid_rst_cycles", out_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        // Back-to-back offers: one idle cycle between consume and next accept
        send({4'd8, 4'd8}, 4'b0000);
        repeat (4) @(negedge clk);
        chk("b2b_first_done", out_valid, 1);
        in_valid  = 1'b1;
        in_bxs    = {4'd8, 4'd8};
        in_trunc  = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_bubble_ready", in_ready, 1);
        chk("b2b_bubble_busy",  busy, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_second_busy", busy, 1);
        repeat (6) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Randomized traffic, checked every cycle against the model
        for (int cyc = 0; cyc < 5000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_bxs    = CW'($urandom);
            in_trunc  = ($urandom_range(0, 1) == 0) ? 4'b0000 : WIDTH'($urandom);
            abort     = ($urandom_range(0, 299) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
